// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The branch-target table below is the default program's jump map.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 9;
  localparam int LUT_AW_DEF  = 5;
  localparam int BT_DEPTH    = 2 ** LUT_AW_DEF;

  localparam logic [INSTR_W_DEF-1:0] HALT_CODE_DEF = 9'h1FF;

  // Entry i jumps to PC 20*i.
  localparam logic [PC_W_DEF-1:0] BRANCH_TARGETS [BT_DEPTH] = '{
    10'd0,   10'd20,  10'd40,  10'd60,
    10'd80,  10'd100, 10'd120, 10'd140,
    10'd160, 10'd180, 10'd200, 10'd220,
    10'd240, 10'd260, 10'd280, 10'd300,
    10'd320, 10'd340, 10'd360, 10'd380,
    10'd400, 10'd420, 10'd440, 10'd460,
    10'd480, 10'd500, 10'd520, 10'd540,
    10'd560, 10'd580, 10'd600, 10'd620
  };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target lookup: idx -> target PC.
// Table entries are zero-extended or truncated to PC_W.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic [LUT_AW-1:0] idx,
  output logic [PC_W-1:0]   target
);

  localparam int TGT_W = PC_W_DEF;
  localparam int MAX_W = (PC_W > TGT_W) ? PC_W : TGT_W;

  logic [TGT_W-1:0] raw;
  logic [MAX_W-1:0] ext;

  // Indices past the table end read as zero.
  always_comb begin
    raw = '0;
    for (int i = 0; i < BT_DEPTH; i++) begin
      if (int'(idx) == i) raw = BRANCH_TARGETS[i];
    end
  end

  assign ext    = MAX_W'(raw);
  assign target = ext[PC_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, redirects on taken branches, halts.
// Define FETCH_CYCLE_COUNT_EN to build the saturating RUN-cycle counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 LUT_AW    = LUT_AW_DEF,
  parameter logic [INSTR_W-1:0] HALT_CODE = INSTR_W'(HALT_CODE_DEF)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               branch,
  input  logic               take,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               done,
  output logic [31:0]        cycle_count
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_target;
  logic            halt;
  logic            start_ok;

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .idx    (instr_in[LUT_AW-1:0]),
    .target (lut_target)
  );

  assign halt     = (instr_in == HALT_CODE);
  assign start_ok = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (branch && take) begin
          pc_d = lut_target;
        end else if (pc_q == '1) begin
          state_d = DONE;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (state_q == RUN && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

  assign pc          = pc_q;
  assign instr_out   = instr_in;
  assign instr_valid = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, halt, branch, reset, PC end.
// Expected cycle_count depends on FETCH_CYCLE_COUNT_EN.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset, start, branch, take;
  logic [8:0]  instr_in;
  logic [9:0]  pc;
  logic [8:0]  instr_out;
  logic        instr_valid, done;
  logic [31:0] cycle_count;

  logic        r4, s4;
  logic [8:0]  i4;
  logic [3:0]  pc4;
  logic [8:0]  io4;
  logic        v4, d4;
  logic [31:0] cc4;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  fetch_unit u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .instr_in    (instr_in),
    .branch      (branch),
    .take        (take),
    .pc          (pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .done        (done),
    .cycle_count (cycle_count)
  );

  fetch_unit #(.PC_W(4)) u_dut4 (
    .Clk         (Clk),
    .Reset       (r4),
    .start       (s4),
    .instr_in    (i4),
    .branch      (1'b0),
    .take        (1'b0),
    .pc          (pc4),
    .instr_out   (io4),
    .instr_valid (v4),
    .done        (d4),
    .cycle_count (cc4)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] cc_exp(input int n);
`ifdef FETCH_CYCLE_COUNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  initial begin
    Reset = 1'b1; start = 1'b0; branch = 1'b0; take = 1'b0;
    instr_in = 9'h010;
    r4 = 1'b1; s4 = 1'b0; i4 = 9'h010;
    step();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_cc", cycle_count, 32'd0);

    Reset = 1'b0;
    step();
    check("idle_valid", 32'(instr_valid), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_pc", 32'(pc), 32'd0);
    check("start_valid", 32'(instr_valid), 32'd1);
    check("instr_fwd", 32'(instr_out), 32'h010);
    step();
    check("seq_pc1", 32'(pc), 32'd1);
    step();
    check("seq_pc2", 32'(pc), 32'd2);
    step();
    check("seq_pc3", 32'(pc), 32'd3);
    check("seq_done", 32'(done), 32'd0);

    instr_in = 9'h1FF;
    step();
    check("halt_done", 32'(done), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_pc", 32'(pc), 32'd3);
    check("halt_cc", cycle_count, cc_exp(4));
    instr_in = 9'h010;
    step();
    check("done_hold_pc", 32'(pc), 32'd3);
    check("done_hold_cc", cycle_count, cc_exp(4));

    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_cc", cycle_count, cc_exp(0));
    for (int i = 0; i < 5; i++) step();
    check("pc5", 32'(pc), 32'd5);

    branch = 1'b1; take = 1'b0; instr_in = 9'h0E2;
    step();
    check("br_not_taken", 32'(pc), 32'd6);
    take = 1'b1;
    step();
    check("br_taken", 32'(pc), 32'd40);
    check("br_valid", 32'(instr_valid), 32'd1);
    branch = 1'b0; take = 1'b0; instr_in = 9'h010;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_run", 32'(pc), 32'd41);

    branch = 1'b1; take = 1'b1; instr_in = 9'h1FF;
    step();
    check("halt_vs_br_done", 32'(done), 32'd1);
    check("halt_vs_br_pc", 32'(pc), 32'd41);
    check("halt_vs_br_cc", cycle_count, cc_exp(9));
    branch = 1'b0; take = 1'b0; instr_in = 9'h010;

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("pc7", 32'(pc), 32'd7);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_cc", cycle_count, 32'd0);
    step();
    check("midrst_idle_pc", 32'(pc), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("after_rst_pc1", 32'(pc), 32'd1);

    r4 = 1'b0;
    s4 = 1'b1;
    step();
    s4 = 1'b0;
    check("w4_start", 32'(pc4), 32'd0);
    for (int i = 0; i < 15; i++) step();
    check("w4_pc15", 32'(pc4), 32'd15);
    check("w4_valid", 32'(v4), 32'd1);
    step();
    check("w4_done", 32'(d4), 32'd1);
    check("w4_nowrap", 32'(pc4), 32'd15);
    check("w4_cc", cc4, cc_exp(16));
    step();
    check("w4_hold", 32'(pc4), 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Owns the program counter and drives the instruction-memory address.
- Presents the fetched instruction and a valid flag to the decoder.
- Consumes the decoder's Branch output plus an ALU condition flag to redirect the PC through a branch-target lookup table, and detects program halt/end to raise done.

Parameters:
- PC_W, 10: program counter width; instruction memory depth is 2**PC_W.
- INSTR_W, 9: machine-code word width.
- LUT_AW, 5: branch-target table index width; index = instr_in[LUT_AW-1:0].
- HALT_CODE, 9'h1FF: instruction encoding that halts execution.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution at PC 0.
- instr_in  input  INSTR_W  instruction memory data at address pc; combinational read.
- branch  input  1  Branch output of the control decoder for the current instr_out.
- take  input  1  ALU condition flag; branch is taken when branch && take.
- pc  output  PC_W  registered instruction memory address.
- instr_out  output  INSTR_W  instruction forwarded to the decoder; equals instr_in.
- instr_valid  output  1  high while in RUN.
- done  output  1  high while in DONE.
- cycle_count  output  32  executed-cycle counter (optional feature).

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values: state=IDLE, pc=0, done=0, instr_valid=0, cycle_count=0.
- Reset mid-operation: on the next edge, return to IDLE with all reset values.
- FSM states: IDLE, RUN, DONE; state is registered, outputs are decoded from it.
- IDLE:
  - pc holds 0, instr_valid=0.
  - start=1 -> RUN on the next edge, with pc=0.
- RUN: instr_valid=1, instr_out=instr_in. Next-PC priority each edge:
  1. instr_in==HALT_CODE -> DONE; pc holds. Halt beats a simultaneous branch.
  2. branch&&take -> pc = branch_lut[instr_in[LUT_AW-1:0]], zero-extended or truncated to PC_W.
  3. pc == 2**PC_W-1 -> DONE; pc holds. No wrap-around.
  4. Otherwise pc = pc+1.
- branch=1 with take=0 -> sequential pc+1.
- start is ignored in RUN.
- DONE:
  - done=1, instr_valid=0, pc frozen.
  - start=1 -> RUN with pc=0, done=0 on the next edge.
- Latency: the instruction at a new pc is valid in the same cycle the pc register updates; one instruction per cycle with no bubbles, including on a taken branch.
- No combinational path from inputs to pc; branch/take affect pc only at the clock edge.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- With the macro defined:
  - cycle_count increments by 1 on every edge spent in RUN, including the edge that leaves RUN.
  - Clears to 0 when start is accepted.
  - Saturates at 32'hFFFF_FFFF.
  - Holds its value in IDLE and DONE.
- Without the macro: no counter register; cycle_count is tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, RUN, DONE};
  - default HALT_CODE constant;
  - BRANCH_TARGETS constant array of 2**LUT_AW entries, PC_W-wide.
- One sub-module: branch_lut, a purely combinational table lookup (idx -> target) built from BRANCH_TARGETS.

Test Plan:
- Reset, pulse start, hold instr_in=9'h010, branch=0 -> pc steps 0,1,2,3 on successive edges; instr_valid=1; done=0.
- Start, then drive instr_in=HALT_CODE while pc=3 -> next edge done=1, instr_valid=0, pc stays 3; with FETCH_CYCLE_COUNT_EN, cycle_count=4.
- At pc=5, branch=1, take=1, instr_in[4:0]=2, BRANCH_TARGETS[2]=40 -> pc=40 next edge; repeat with take=0 -> pc=6; HALT_CODE with branch=take=1 -> DONE, pc unchanged.
- PC_W=4, sequential instructions -> pc reaches 15, then DONE with pc held at 15 (no wrap to 0).
- Assert Reset for one cycle while pc=7 in RUN -> next edge state IDLE, pc=0, done=0, instr_valid=0; a later start restarts from pc 0.
- From DONE, pulse start -> next edge pc=0, done=0, instr_valid=1, cycle_count=0 (macro on); start pulsed during RUN -> no effect on pc.
